// File: rtl/prog_loader.sv
// prog_loader: boot-time byte-stream loader that fills instruction memory, then releases the CPU.
// Define LOADER_CHECKSUM_EN to require a trailing 32-bit checksum word after the data words.
module prog_loader #(
    parameter int ADDR_W     = 10,
    parameter int MAX_WORDS  = 1024,
    parameter int RESET_HOLD = 4
) (
    input  logic              clk,
    input  logic              ld_reset_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [ADDR_W:0] IDX_ONE = 1;
    localparam logic [HW-1:0]   HOLD_ONE = 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(RESET_HOLD - 1);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {HDR, DATA, CSUM, HOLD, RUN, ERR} state_t;
`else
    typedef enum logic [2:0] {HDR, DATA, HOLD, RUN, ERR} state_t;
`endif

    state_t            state_q;
    logic [1:0]        cnt_q;
    logic [23:0]       word_q;
    logic [ADDR_W:0]   n_q;
    logic [ADDR_W:0]   idx_q;
    logic [HW-1:0]     hold_q;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]       sum_q;
`endif
    logic              in_ready_q;
    logic              imem_we_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [31:0]       imem_wdata_q;
    logic              cpu_hold_q;
    logic              done_q;
    logic              error_q;

    logic              acc_w;
    logic              last_w;
    logic [31:0]       full_w;
    logic [ADDR_W:0]   idx_nx_w;

    assign acc_w    = in_valid && in_ready_q;
    assign last_w   = acc_w && (cnt_q == 2'd3);
    assign full_w   = {in_data, word_q};
    assign idx_nx_w = idx_q + IDX_ONE;

    always_ff @(posedge clk or negedge ld_reset_n) begin
        if (!ld_reset_n) begin
            state_q      <= HDR;
            cnt_q        <= '0;
            word_q       <= '0;
            n_q          <= '0;
            idx_q        <= '0;
            hold_q       <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            imem_we_q <= 1'b0;
            if (acc_w) begin
                cnt_q <= cnt_q + 2'd1;
                unique case (cnt_q)
                    2'd0:    word_q[7:0]   <= in_data;
                    2'd1:    word_q[15:8]  <= in_data;
                    2'd2:    word_q[23:16] <= in_data;
                    default: ;
                endcase
            end
            unique case (state_q)
                HDR: begin
                    in_ready_q <= 1'b1;
                    if (last_w) begin
                        n_q   <= full_w[ADDR_W:0];
                        idx_q <= '0;
`ifdef LOADER_CHECKSUM_EN
                        sum_q <= '0;
`endif
                        if (full_w > 32'(MAX_WORDS)) begin
                            state_q    <= ERR;
                            in_ready_q <= 1'b0;
                            error_q    <= 1'b1;
                        end else if (full_w == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            state_q    <= CSUM;
`else
                            state_q    <= HOLD;
                            hold_q     <= '0;
                            in_ready_q <= 1'b0;
`endif
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (last_w) begin
                        imem_we_q    <= 1'b1;
                        imem_addr_q  <= idx_q[ADDR_W-1:0];
                        imem_wdata_q <= full_w;
                        idx_q        <= idx_nx_w;
`ifdef LOADER_CHECKSUM_EN
                        sum_q        <= sum_q + full_w;
`endif
                        // Hold count starts alongside the final write strobe
                        if (idx_nx_w == n_q) begin
`ifdef LOADER_CHECKSUM_EN
                            state_q    <= CSUM;
`else
                            state_q    <= HOLD;
                            hold_q     <= '0;
                            in_ready_q <= 1'b0;
`endif
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CSUM: begin
                    if (last_w) begin
                        in_ready_q <= 1'b0;
                        if (full_w == sum_q) begin
                            state_q <= HOLD;
                            hold_q  <= '0;
                        end else begin
                            state_q <= ERR;
                            error_q <= 1'b1;
                        end
                    end
                end
`endif
                HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_q    <= RUN;
                        cpu_hold_q <= 1'b0;
                        done_q     <= 1'b1;
                    end else begin
                        hold_q <= hold_q + HOLD_ONE;
                    end
                end
                RUN, ERR: ;
                default: begin
                    state_q    <= ERR;
                    in_ready_q <= 1'b0;
                    error_q    <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed-vector bench for prog_loader.
// Build with +define+LOADER_CHECKSUM_EN to exercise the checksum variant.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        ld_reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    prog_loader #(
        .ADDR_W(10),
        .MAX_WORDS(1024),
        .RESET_HOLD(4)
    ) dut (
        .clk(clk),
        .ld_reset_n(ld_reset_n),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int miss = 0;
    int cyc = 0;

    logic [9:0]  wa[$];
    logic [31:0] wd[$];
    int  we_cyc = 0;
    int  done_cyc = 0;
    int  fall_cyc = 0;
    bit  done_seen = 1'b0;
    bit  fall_seen = 1'b0;

    always @(posedge clk) cyc++;

    // Write/event monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!ld_reset_n) begin
            done_seen = 1'b0;
            fall_seen = 1'b0;
        end else begin
            if (imem_we) begin
                wa.push_back(imem_addr);
                wd.push_back(imem_wdata);
                we_cyc = cyc;
            end
            if (done && !done_seen) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
            if (!cpu_hold && !fall_seen) begin
                fall_seen = 1'b1;
                fall_cyc  = cyc;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            vec++;
            miss++;
            $display("FAIL send_byte timeout: in_ready=%0b required 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input bit rnd);
        for (int i = 0; i < 4; i++) begin
            if (rnd) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                    @(negedge clk);
                end
            end
            send_byte(w[8*i +: 8]);
        end
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && !error && t < 60) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 60) begin
            vec++;
            miss++;
            $display("FAIL wait_done timeout: done=%0b required 1", done);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        ld_reset_n = 1'b0;
        in_valid   = 1'b0;
        repeat (2) @(negedge clk);
        ld_reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        ld_reset_n = 1'b0;
        repeat (3) @(negedge clk);
        vec++; if (in_ready !== 1'b0) begin miss++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
        vec++; if (imem_we !== 1'b0) begin miss++; $display("FAIL rst_we: got %0b want 0", imem_we); end
        vec++; if (imem_addr !== 10'd0) begin miss++; $display("FAIL rst_addr: got %0h want 0", imem_addr); end
        vec++; if (imem_wdata !== 32'd0) begin miss++; $display("FAIL rst_wdata: got %0h want 0", imem_wdata); end
        vec++; if (cpu_hold !== 1'b1) begin miss++; $display("FAIL rst_hold: got %0b want 1", cpu_hold); end
        vec++; if (done !== 1'b0) begin miss++; $display("FAIL rst_done: got %0b want 0", done); end
        vec++; if (error !== 1'b0) begin miss++; $display("FAIL rst_error: got %0b want 0", error); end
        ld_reset_n = 1'b1;
        #1;
        vec++; if (in_ready !== 1'b0) begin miss++; $display("FAIL rdy_pre_edge: got %0b want 0", in_ready); end
        @(negedge clk);
        vec++; if (in_ready !== 1'b1) begin miss++; $display("FAIL rdy_post_edge: got %0b want 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        int base = wa.size();
        int s = cyc;
        logic [31:0] exp_d [3] = '{32'h00500093, 32'h00A00113, 32'h002081B3};
        send_word(32'd3, 1'b0);
        for (int i = 0; i < 3; i++) send_word(exp_d[i], 1'b0);
        vec++; if (cyc - s !== 16) begin miss++; $display("FAIL b2b_rate: got %0d cycles want 16", cyc - s); end
`ifdef LOADER_CHECKSUM_EN
        send_word(32'h01108359, 1'b0);
`endif
        in_valid = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);
        #1;
        vec++; if (wa.size() - base !== 3) begin miss++; $display("FAIL b2b_count: got %0d want 3", wa.size() - base); end
        if (wa.size() - base >= 3) begin
            for (int i = 0; i < 3; i++) begin
                vec++; if (wa[base+i] !== 10'(i)) begin miss++; $display("FAIL b2b_addr%0d: got %0d want %0d", i, wa[base+i], i); end
                vec++; if (wd[base+i] !== exp_d[i]) begin miss++; $display("FAIL b2b_data%0d: got %h want %h", i, wd[base+i], exp_d[i]); end
            end
        end
`ifndef LOADER_CHECKSUM_EN
        vec++; if (fall_cyc - we_cyc !== 4) begin miss++; $display("FAIL b2b_hold_fall: got %0d want 4", fall_cyc - we_cyc); end
`endif
        vec++; if (done_cyc !== fall_cyc) begin miss++; $display("FAIL b2b_done_cyc: got %0d want %0d", done_cyc, fall_cyc); end
        vec++; if (cpu_hold !== 1'b0) begin miss++; $display("FAIL b2b_hold: got %0b want 0", cpu_hold); end
        vec++; if (done !== 1'b1) begin miss++; $display("FAIL b2b_done: got %0b want 1", done); end
        vec++; if (in_ready !== 1'b0) begin miss++; $display("FAIL b2b_rdy: got %0b want 0", in_ready); end
        base = wa.size();
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (8) @(negedge clk);
        in_valid = 1'b0;
        #1;
        vec++; if (wa.size() !== base) begin miss++; $display("FAIL run_ignore: got %0d writes want 0", wa.size() - base); end
        vec++; if (done !== 1'b1) begin miss++; $display("FAIL run_sticky: got %0b want 1", done); end
    endtask

    task automatic test_stall();
        int base;
        logic [31:0] exp_d [3] = '{32'h00500093, 32'h00A00113, 32'h002081B3};
        do_reset();
        base = wa.size();
        send_word(32'd3, 1'b1);
        for (int i = 0; i < 3; i++) send_word(exp_d[i], 1'b1);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'h01108359, 1'b1);
`endif
        in_valid = 1'b0;
        wait_done();
        repeat (2) @(negedge clk);
        #1;
        vec++; if (wa.size() - base !== 3) begin miss++; $display("FAIL stall_count: got %0d want 3", wa.size() - base); end
        if (wa.size() - base >= 3) begin
            for (int i = 0; i < 3; i++) begin
                vec++; if (wa[base+i] !== 10'(i)) begin miss++; $display("FAIL stall_addr%0d: got %0d want %0d", i, wa[base+i], i); end
                vec++; if (wd[base+i] !== exp_d[i]) begin miss++; $display("FAIL stall_data%0d: got %h want %h", i, wd[base+i], exp_d[i]); end
            end
        end
        vec++; if (done !== 1'b1) begin miss++; $display("FAIL stall_done: got %0b want 1", done); end
    endtask

    task automatic test_overflow();
        int base;
        do_reset();
        base = wa.size();
        send_word(32'd1025, 1'b0);
        in_valid = 1'b0;
        #1;
        vec++; if (error !== 1'b1) begin miss++; $display("FAIL ovf_error: got %0b want 1", error); end
        vec++; if (in_ready !== 1'b0) begin miss++; $display("FAIL ovf_rdy: got %0b want 0", in_ready); end
        in_valid = 1'b1;
        repeat (8) @(negedge clk);
        in_valid = 1'b0;
        #1;
        vec++; if (wa.size() !== base) begin miss++; $display("FAIL ovf_writes: got %0d want 0", wa.size() - base); end
        vec++; if (cpu_hold !== 1'b1) begin miss++; $display("FAIL ovf_hold: got %0b want 1", cpu_hold); end
        vec++; if (done !== 1'b0) begin miss++; $display("FAIL ovf_done: got %0b want 0", done); end
        vec++; if (error !== 1'b1) begin miss++; $display("FAIL ovf_sticky: got %0b want 1", error); end
    endtask

    task automatic test_zero();
        int base;
        int t0;
        do_reset();
        base = wa.size();
        send_word(32'd0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'd0, 1'b0);
`endif
        in_valid = 1'b0;
        t0 = cyc;
        wait_done();
        #1;
        vec++; if (done_cyc - t0 !== 4) begin miss++; $display("FAIL zero_done_cyc: got %0d want 4", done_cyc - t0); end
        vec++; if (fall_cyc - t0 !== 4) begin miss++; $display("FAIL zero_hold_cyc: got %0d want 4", fall_cyc - t0); end
        vec++; if (wa.size() !== base) begin miss++; $display("FAIL zero_writes: got %0d want 0", wa.size() - base); end
        vec++; if (error !== 1'b0) begin miss++; $display("FAIL zero_error: got %0b want 0", error); end
    endtask

    task automatic test_max();
        int base;
        logic [31:0] sum = 32'd0;
        do_reset();
        base = wa.size();
        send_word(32'd1024, 1'b0);
        for (int i = 0; i < 1024; i++) begin
            send_word(32'hA5000000 | 32'(i), 1'b0);
            sum = sum + (32'hA5000000 | 32'(i));
        end
`ifdef LOADER_CHECKSUM_EN
        send_word(sum, 1'b0);
`endif
        in_valid = 1'b0;
        wait_done();
        #1;
        vec++; if (wa.size() - base !== 1024) begin miss++; $display("FAIL max_count: got %0d want 1024", wa.size() - base); end
        if (wa.size() - base >= 1024) begin
            vec++; if (wa[base+1023] !== 10'd1023) begin miss++; $display("FAIL max_last_addr: got %0d want 1023", wa[base+1023]); end
            vec++; if (wd[base+1023] !== 32'hA50003FF) begin miss++; $display("FAIL max_last_data: got %h want a50003ff", wd[base+1023]); end
            vec++; if (wa[base+512] !== 10'd512) begin miss++; $display("FAIL max_mid_addr: got %0d want 512", wa[base+512]); end
        end
        vec++; if (done !== 1'b1) begin miss++; $display("FAIL max_done: got %0b want 1", done); end
        vec++; if (error !== 1'b0) begin miss++; $display("FAIL max_error: got %0b want 0", error); end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_csum();
        int base;
        do_reset();
        send_word(32'd2, 1'b0);
        send_word(32'd1, 1'b0);
        send_word(32'd2, 1'b0);
        send_word(32'd3, 1'b0);
        in_valid = 1'b0;
        wait_done();
        vec++; if (done !== 1'b1) begin miss++; $display("FAIL csum_ok_done: got %0b want 1", done); end
        vec++; if (error !== 1'b0) begin miss++; $display("FAIL csum_ok_err: got %0b want 0", error); end
        do_reset();
        base = wa.size();
        send_word(32'd2, 1'b0);
        send_word(32'd1, 1'b0);
        send_word(32'd2, 1'b0);
        send_word(32'd4, 1'b0);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        vec++; if (error !== 1'b1) begin miss++; $display("FAIL csum_bad_err: got %0b want 1", error); end
        vec++; if (wa.size() - base !== 2) begin miss++; $display("FAIL csum_bad_writes: got %0d want 2", wa.size() - base); end
        vec++; if (cpu_hold !== 1'b1) begin miss++; $display("FAIL csum_bad_hold: got %0b want 1", cpu_hold); end
        vec++; if (done !== 1'b0) begin miss++; $display("FAIL csum_bad_done: got %0b want 0", done); end
    endtask
`endif

    task automatic test_reset_midword();
        int base;
        do_reset();
        send_word(32'd1, 1'b0);
        send_byte(8'hEE);
        send_byte(8'hDD);
        in_valid = 1'b0;
        #2;
        ld_reset_n = 1'b0;
        #1;
        vec++; if (in_ready !== 1'b0) begin miss++; $display("FAIL mid_rst_rdy: got %0b want 0", in_ready); end
        vec++; if (cpu_hold !== 1'b1) begin miss++; $display("FAIL mid_rst_hold: got %0b want 1", cpu_hold); end
        repeat (2) @(negedge clk);
        ld_reset_n = 1'b1;
        @(negedge clk);
        base = wa.size();
        send_word(32'd1, 1'b0);
        send_word(32'hCAFEF00D, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'hCAFEF00D, 1'b0);
`endif
        in_valid = 1'b0;
        wait_done();
        #1;
        vec++; if (wa.size() - base !== 1) begin miss++; $display("FAIL mid_count: got %0d want 1", wa.size() - base); end
        if (wa.size() - base >= 1) begin
            vec++; if (wa[base] !== 10'd0) begin miss++; $display("FAIL mid_addr: got %0d want 0", wa[base]); end
            vec++; if (wd[base] !== 32'hCAFEF00D) begin miss++; $display("FAIL mid_data: got %h want cafef00d", wd[base]); end
        end
        vec++; if (done !== 1'b1) begin miss++; $display("FAIL mid_done: got %0b want 1", done); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_overflow();
        test_zero();
        test_max();
`ifdef LOADER_CHECKSUM_EN
        test_csum();
`endif
        test_reset_midword();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
